imem_arbiter: RTL and testbench
===============================

Name: imem_arbiter

Overview:
- Shares the single-ported instruction memory between the core fetch port (read-only) and the program-loader/debug port (read/write).
- Sits between the fetch stage, the loader, and the instruction memory array.
- Adds a boot hold that blocks fetch until loading completes.
- Arbitrates each cycle with loader priority and a starvation guard for fetch.
- Routes 1-cycle-latency read data back to the requester that issued the read.

Parameters:
- ADDR_W, 32, byte-address width of both requester ports.
- DATA_W, 32, memory word width.
- STARVE_LIMIT, 4, max consecutive loader grants while fetch is waiting; range 1..15.
- BOOT_WAIT, 1, 1 = start in BOOT state after reset; 0 = start in RUN.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- f_req  in  1  fetch request, held until f_gnt
- f_addr  in  ADDR_W  fetch byte address
- f_gnt  out  1  fetch command accepted this cycle
- f_rvalid  out  1  fetch read data valid
- f_rdata  out  DATA_W  fetch read data
- l_req  in  1  loader request, held until l_gnt
- l_we  in  1  loader write (1) / read (0)
- l_addr  in  ADDR_W  loader byte address
- l_wdata  in  DATA_W  loader write data
- l_gnt  out  1  loader command accepted
- l_rvalid  out  1  loader read data valid
- l_rdata  out  DATA_W  loader read data
- boot_done  in  1  one-cycle pulse: loader finished; release fetch
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W-2  word address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en with mem_we=0
- booting  out  1  high while in BOOT state

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, port name reset.
- Reset values: f_rvalid=0, l_rvalid=0, f_rdata=32'h00000013 (NOP), l_rdata=0, starvation counter=0, rsp_owner=none, state=BOOT if BOOT_WAIT else RUN. Reset asserted mid-read drops the pending response; no rvalid is issued after reset deasserts.
- FSM states:
  - BOOT: only the loader may be granted; f_gnt=0.
  - RUN: normal arbitration.
  - Transitions: BOOT->RUN on boot_done (takes effect next cycle). RUN has no exit except reset. boot_done in RUN is ignored.
- Grant logic (combinational, same cycle):
  - Priority is loader > fetch.
  - Exception: in RUN, if the counter equals STARVE_LIMIT and f_req=1, fetch wins.
  - At most one of f_gnt/l_gnt is high per cycle.
  - mem_en = f_gnt|l_gnt.
  - mem_we = l_gnt&l_we.
  - mem_addr = granted addr[ADDR_W-1:2]; bits [1:0] are ignored (no misalignment fault).
  - mem_wdata = l_wdata.
- Starvation counter, 4 bits:
  - increments on l_gnt while f_req=1 in RUN;
  - clears on f_gnt or when f_req=0;
  - saturates at STARVE_LIMIT.
- Response path:
  - rsp_owner is registered from the grant of a read; a write leaves it at none.
  - Cycle N+1: the owner's rvalid=1 for exactly one cycle; its rdata is registered from mem_rdata and holds until the next response to that owner.
  - Back-to-back grants are fully pipelined, one command per cycle.
  - Loader writes produce no l_rvalid.
- f_rdata retains the NOP value until the first fetch response.
- Simultaneous events:
  - boot_done in the same cycle as f_req: fetch is not granted that cycle.
  - l_req and f_req both high in RUN below the limit: loader is granted.

Optional Feature:
- Macro: IMEM_ARB_STATS_EN.
- When defined, adds output port f_stall_cnt (32 bits). It counts cycles with f_req=1 and f_gnt=0 (BOOT cycles included), saturates at 32'hFFFFFFFF, and resets to 0.
- When undefined, the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package imem_pkg:
  - NOP_INSN = 32'h00000013
  - owner encoding constants OWN_NONE/OWN_F/OWN_L (2 bits)
  - state constants ST_BOOT/ST_RUN
- One natural sub-module: imem_starve_ctr (saturating counter with clear/inc/limit compare). Everything else stays in imem_arbiter.

Test Plan:
- Reset, BOOT_WAIT=1, f_req=1 addr 0x40 for 10 cycles -> f_gnt=0 throughout, booting=1, f_rdata=0x00000013; then boot_done pulse -> f_gnt the next cycle, mem_addr=0x10, f_rvalid one cycle later with the mem word.
- Loader write l_addr 0x8 data 0xDEADBEEF, then loader read 0x8 -> mem_we=1 mem_addr=2 on the write; l_rvalid=1 with 0xDEADBEEF one cycle after the read grant; no l_rvalid for the write.
- RUN, l_req and f_req held high continuously, STARVE_LIMIT=4 -> grant pattern L,L,L,L,F repeating; f_rvalid follows each F grant by exactly 1 cycle.
- Alternating fetch reads to 0x0,0x4,0x8 back-to-back -> f_gnt every cycle, f_rvalid on 3 consecutive cycles with words 0,1,2 in order.
- Assert reset the cycle after a fetch grant -> no f_rvalid, f_rdata=0x00000013, state returns to BOOT.
- IMEM_ARB_STATS_EN defined, 7 stalled fetch cycles -> f_stall_cnt=7.

Source files
------------

// File: rtl/imem_pkg.sv
// imem_pkg: shared constants and types for the instruction-memory arbiter
// Contents: NOP_INSN reset value for fetch data, response-owner codes, FSM state type.
package imem_pkg;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_F = 2'd1;
    localparam logic [1:0] OWN_L = 2'd2;
    typedef enum logic {ST_BOOT, ST_RUN} state_t;
endpackage

// File: rtl/imem_starve_ctr.sv
// imem_starve_ctr: 4-bit saturating count of loader wins while fetch waits
// Ports: clk, reset (async, active-high), clr_i (clear, dominant), inc_i (count up),
//        at_limit_o (count has reached LIMIT).
module imem_starve_ctr #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic inc_i,
    output logic at_limit_o
);
    logic [3:0] cnt_q, cnt_d;
    assign at_limit_o = cnt_q == 4'(LIMIT);
    always_comb cnt_d = clr_i ? 4'd0 : (inc_i && !at_limit_o) ? cnt_q + 4'd1 : cnt_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares a single-ported instruction memory between fetch and loader
// Ports: clk, reset (async, active-high)
//        f_*  fetch port (read-only): req/addr in, gnt/rvalid/rdata out
//        l_*  loader/debug port (read/write): req/we/addr/wdata in, gnt/rvalid/rdata out
//        boot_done  pulse releasing fetch from BOOT; booting high while in BOOT
//        mem_*  memory side: en/we/addr(word)/wdata out, rdata in (1-cycle latency)
//        f_stall_cnt  only when IMEM_ARB_STATS_EN is defined: saturating stalled-fetch cycles
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter bit BOOT_WAIT = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    input  logic              boot_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              booting
`ifdef IMEM_ARB_STATS_EN
    ,
    output logic [31:0]       f_stall_cnt
`endif
);
    state_t state_q, state_d;
    logic [1:0] own_q, own_d;
    logic [DATA_W-1:0] f_rdata_q, f_rdata_d, l_rdata_q, l_rdata_d;
    logic run, at_limit, starve;
    logic unused_addr_bits;
    assign unused_addr_bits = ^{f_addr[1:0], l_addr[1:0]};
    assign run = state_q == ST_RUN;
    assign booting = !run;
    // Fetch overrides the loader only once it has lost STARVE_LIMIT times in a row.
    assign starve = run && at_limit && f_req;
    assign f_gnt = (run && f_req && !l_req) || starve;
    assign l_gnt = l_req && !starve;
    assign mem_en = f_gnt || l_gnt;
    assign mem_we = l_gnt && l_we;
    assign mem_addr = f_gnt ? f_addr[ADDR_W-1:2] : l_addr[ADDR_W-1:2];
    assign mem_wdata = l_wdata;
    imem_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (f_gnt || !f_req),
        .inc_i      (l_gnt && f_req && run),
        .at_limit_o (at_limit)
    );
    // Read data is steered straight from memory in the response cycle and
    // captured so it stays visible until that requester's next response.
    assign f_rvalid = own_q == OWN_F;
    assign l_rvalid = own_q == OWN_L;
    assign f_rdata = f_rvalid ? mem_rdata : f_rdata_q;
    assign l_rdata = l_rvalid ? mem_rdata : l_rdata_q;
    always_comb begin
        state_d = (state_q == ST_BOOT && boot_done) ? ST_RUN : state_q;
        own_d = f_gnt ? OWN_F : (l_gnt && !l_we) ? OWN_L : OWN_NONE;
        f_rdata_d = f_rvalid ? mem_rdata : f_rdata_q;
        l_rdata_d = l_rvalid ? mem_rdata : l_rdata_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT_WAIT ? ST_BOOT : ST_RUN;
            own_q <= OWN_NONE;
            f_rdata_q <= DATA_W'(NOP_INSN);
            l_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            own_q <= own_d;
            f_rdata_q <= f_rdata_d;
            l_rdata_q <= l_rdata_d;
        end
    end
`ifdef IMEM_ARB_STATS_EN
    logic [31:0] stall_q, stall_d;
    assign f_stall_cnt = stall_q;
    always_comb stall_d = (f_req && !f_gnt && stall_q != '1) ? stall_q + 32'd1 : stall_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_q <= '0;
        else stall_q <= stall_d;
    end
`endif
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: randomized scoreboard bench for imem_arbiter with a behavioural memory model
module tb_imem_arbiter;
    localparam int LIMIT = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic clk = 0, reset = 1;
    logic f_req = 0, l_req = 0, l_we = 0, boot_done = 0;
    logic [31:0] f_addr = 0, l_addr = 0, l_wdata = 0;
    logic f_gnt, f_rvalid, l_gnt, l_rvalid, mem_en, mem_we, booting;
    logic [31:0] f_rdata, l_rdata, mem_wdata, mem_rdata = 0;
    logic [29:0] mem_addr;
`ifdef IMEM_ARB_STATS_EN
    logic [31:0] f_stall_cnt;
`endif
    int n_cmp = 0, n_err = 0;
    imem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT), .BOOT_WAIT(1'b1)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_gnt(l_gnt),
        .l_rvalid(l_rvalid), .l_rdata(l_rdata), .boot_done(boot_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .booting(booting)
`ifdef IMEM_ARB_STATS_EN
        , .f_stall_cnt(f_stall_cnt)
`endif
    );
    always #5 clk = ~clk;
    // Memory array outside the DUT: unwritten word k reads back as k.
    logic [31:0] emem [int];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) emem[int'(mem_addr[7:0])] = mem_wdata;
            else mem_rdata <= emem.exists(int'(mem_addr[7:0])) ? emem[int'(mem_addr[7:0])] : 32'(mem_addr[7:0]);
        end
    end
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask
    // Reference model: who should win, what the memory holds, which reads are outstanding.
    logic [31:0] rmem [int];
    logic [31:0] qf[$], ql[$];
    logic [31:0] last_f = NOP, last_l = 0, m_stall = 0;
    bit m_run = 0, ev_f = 0, ev_l = 0, f_took = 0, l_took = 0, ef, el;
    int m_wait = 0;
    function automatic logic [31:0] rd(input logic [31:0] a);
        return rmem.exists(int'(a[9:2])) ? rmem[int'(a[9:2])] : 32'(a[9:2]);
    endfunction
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_f_rvalid", 32'(f_rvalid), 0);
            chk("rst_l_rvalid", 32'(l_rvalid), 0);
            chk("rst_f_rdata", f_rdata, NOP);
            chk("rst_l_rdata", l_rdata, 0);
            m_run = 0; m_wait = 0; ev_f = 0; ev_l = 0; f_took = 0; l_took = 0;
            qf.delete(); ql.delete(); last_f = NOP; last_l = 0; m_stall = 0;
        end else begin
            ef = m_run && f_req && (!l_req || m_wait == LIMIT);
            el = l_req && !ef;
            chk("f_gnt", 32'(f_gnt), 32'(ef));
            chk("l_gnt", 32'(l_gnt), 32'(el));
            chk("booting", 32'(booting), 32'(!m_run));
            chk("mem_en", 32'(mem_en), 32'(ef || el));
            if (ef || el) begin
                chk("mem_addr", 32'(mem_addr), (ef ? f_addr : l_addr) >> 2);
                chk("mem_we", 32'(mem_we), 32'(el && l_we));
                if (el && l_we) chk("mem_wdata", mem_wdata, l_wdata);
            end
            chk("f_rvalid", 32'(f_rvalid), 32'(ev_f));
            if (f_rvalid) begin
                if (qf.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL f_unexpected_rsp: got %h expected no response", f_rdata);
                end else last_f = qf.pop_front();
            end
            chk("f_rdata", f_rdata, last_f);
            chk("l_rvalid", 32'(l_rvalid), 32'(ev_l));
            if (l_rvalid) begin
                if (ql.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL l_unexpected_rsp: got %h expected no response", l_rdata);
                end else last_l = ql.pop_front();
            end
            chk("l_rdata", l_rdata, last_l);
`ifdef IMEM_ARB_STATS_EN
            chk("f_stall_cnt", f_stall_cnt, m_stall);
            if (f_req && !ef && m_stall != 32'hFFFF_FFFF) m_stall++;
`endif
            if (ef) qf.push_back(rd(f_addr));
            if (el && !l_we) ql.push_back(rd(l_addr));
            if (el && l_we) rmem[int'(l_addr[9:2])] = l_wdata;
            ev_f = ef;
            ev_l = el && !l_we;
            m_wait = (ef || !f_req) ? 0 : (el && m_run && m_wait < LIMIT) ? m_wait + 1 : m_wait;
            if (boot_done) m_run = 1;
            f_took = f_gnt;
            l_took = l_gnt;
        end
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    // One random cycle: a requester only moves on once its current command was granted.
    task automatic drive(input int pf, input int pl);
        step();
        boot_done = 0;
        if (!f_req || f_took) begin
            f_req = $urandom_range(0, 99) < pf;
            f_addr = $urandom_range(0, 1023);
        end
        if (!l_req || l_took) begin
            l_req = $urandom_range(0, 99) < pl;
            l_we = 1'($urandom_range(0, 1));
            l_addr = $urandom_range(0, 1023);
            l_wdata = $urandom;
        end
    endtask
    initial begin
        step(); step();
        reset = 0; f_req = 1; f_addr = 32'h40;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("boot_f_gnt", 32'(f_gnt), 0);
            chk("boot_booting", 32'(booting), 1);
            chk("boot_f_rdata", f_rdata, NOP);
`ifdef IMEM_ARB_STATS_EN
            if (i == 7) chk("stall_7", f_stall_cnt, 7);
`endif
            step();
        end
        boot_done = 1;
        @(negedge clk); chk("bootdone_f_gnt", 32'(f_gnt), 0);
        step(); boot_done = 0;
        @(negedge clk); chk("run_f_gnt", 32'(f_gnt), 1); chk("run_mem_addr", 32'(mem_addr), 32'h10);
        step(); f_req = 0;
        @(negedge clk); chk("run_f_rvalid", 32'(f_rvalid), 1); chk("run_f_word", f_rdata, 32'h10);
        step(); f_req = 1; f_addr = 0;
        @(negedge clk); chk("b2b_gnt0", 32'(f_gnt), 1);
        step(); f_addr = 4;
        @(negedge clk); chk("b2b_gnt1", 32'(f_gnt), 1); chk("b2b_word0", f_rdata, 0);
        step(); f_addr = 8;
        @(negedge clk); chk("b2b_gnt2", 32'(f_gnt), 1); chk("b2b_word1", f_rdata, 1);
        step(); f_req = 0;
        @(negedge clk); chk("b2b_rv2", 32'(f_rvalid), 1); chk("b2b_word2", f_rdata, 2);
        step(); l_req = 1; l_we = 1; l_addr = 8; l_wdata = 32'hDEAD_BEEF;
        @(negedge clk); chk("lw_we", 32'(mem_we), 1); chk("lw_addr", 32'(mem_addr), 2);
        step(); l_we = 0;
        @(negedge clk); chk("lw_no_rvalid", 32'(l_rvalid), 0); chk("lr_gnt", 32'(l_gnt), 1);
        step(); l_req = 0;
        @(negedge clk); chk("lr_rvalid", 32'(l_rvalid), 1); chk("lr_data", l_rdata, 32'hDEAD_BEEF);
        for (int i = 0; i < 40; i++) drive(100, 100);
        for (int s = 0; s < 12; s++) begin
            int pf = $urandom_range(0, 100), pl = $urandom_range(0, 100);
            for (int i = 0; i < 150; i++) begin
                drive(pf, pl);
                boot_done = $urandom_range(0, 49) == 0;
            end
        end
        step(); boot_done = 0; l_req = 0; f_req = 1; f_addr = 32'h20;
        @(negedge clk); chk("prerst_f_gnt", 32'(f_gnt), 1);
        step(); f_req = 0; reset = 1;
        @(negedge clk); chk("midrst_f_rvalid", 32'(f_rvalid), 0); chk("midrst_booting", 32'(booting), 1);
        step(); reset = 0;
        @(negedge clk); chk("postrst_f_rvalid", 32'(f_rvalid), 0); chk("postrst_f_rdata", f_rdata, NOP);
        for (int i = 0; i < 20; i++) drive(100, 100);
        step(); f_req = 0; l_req = 0;
        step(); step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
